// File: rtl/pb_eoc_aggregator.sv
// Multi-channel end-of-computation collector: tracks a masked set of
// channels reporting Cheshire-style exit words (bit 0 = EOC, upper bits =
// return value) and folds them into one done / exit-code result, with an
// optional cycle timeout.

// Per-channel acceptance: a masked, EOC-flagged, first-time report.
module pb_eoc_chan #(
  parameter int CodeWidth = 32
) (
  input  logic                 valid_i,
  input  logic                 mask_i,
  input  logic                 reported_i,
  input  logic [CodeWidth-1:0] code_i,
  output logic                 accept_o,
  output logic                 fail_o
);
  assign accept_o = valid_i & mask_i & code_i[0] & ~reported_i;
  assign fail_o   = accept_o & (|code_i[CodeWidth-1:1]);
endmodule

module pb_eoc_aggregator #(
  parameter int NumChannels  = 16,
  parameter int CodeWidth    = 32,
  parameter int TimeoutWidth = 32,
  localparam int ChanIdxWidth = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             arm_i,
  input  logic [NumChannels-1:0]           mask_i,
  input  logic                             mode_i,
  input  logic [TimeoutWidth-1:0]          timeout_i,
  input  logic [NumChannels-1:0]           eoc_valid_i,
  input  logic [NumChannels*CodeWidth-1:0] eoc_code_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic [CodeWidth-2:0]             exit_code_o,
  output logic [ChanIdxWidth-1:0]          first_chan_o,
  output logic [NumChannels-1:0]           reported_o,
  output logic [NumChannels-1:0]           fail_mask_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [NumChannels-1:0]  mask_q, mask_d;
  logic                    mode_q, mode_d;
  logic                    tmo_en_q, tmo_en_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;
  logic [NumChannels-1:0]  reported_q, reported_d;
  logic [NumChannels-1:0]  fail_q, fail_d;
  logic                    timeout_q, timeout_d;
  logic [CodeWidth-2:0]    exit_code_q, exit_code_d;
  logic [ChanIdxWidth-1:0] first_chan_q, first_chan_d;

  logic [NumChannels-1:0]  accept, new_fail;
  logic [NumChannels-1:0]  rep_post, fail_post;
  logic [CodeWidth-2:0]    fail_code;
  logic [ChanIdxWidth-1:0] fail_idx, pend_idx;
  logic                    complete, expire;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    pb_eoc_chan #(.CodeWidth(CodeWidth)) u_chan (
      .valid_i   (eoc_valid_i[c]),
      .mask_i    (mask_q[c]),
      .reported_i(reported_q[c]),
      .code_i    (eoc_code_i[c*CodeWidth +: CodeWidth]),
      .accept_o  (accept[c]),
      .fail_o    (new_fail[c])
    );
  end

  // Post-update view of this cycle's reports, plus the priority picks:
  // lowest new failing channel and lowest still-pending masked channel.
  always_comb begin
    rep_post  = reported_q | accept;
    fail_post = fail_q | new_fail;
    fail_code = '0;
    fail_idx  = '0;
    pend_idx  = '0;
    for (int c = NumChannels - 1; c >= 0; c--) begin
      if (new_fail[c]) begin
        fail_code = eoc_code_i[c*CodeWidth+1 +: CodeWidth-1];
        fail_idx  = ChanIdxWidth'(c);
      end
      if (mask_q[c] && !rep_post[c]) pend_idx = ChanIdxWidth'(c);
    end
    complete = ((rep_post & mask_q) == mask_q) || (mode_q && (|fail_post));
    expire   = tmo_en_q && (cnt_q == TimeoutWidth'(1));
  end

  // Next-state: arm from IDLE/DONE, collect reports in RUN; completion
  // takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    mode_d       = mode_q;
    tmo_en_d     = tmo_en_q;
    cnt_d        = cnt_q;
    reported_d   = reported_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    exit_code_d  = exit_code_q;
    first_chan_d = first_chan_q;
    case (state_q)
      IDLE, DONE: begin
        if (arm_i) begin
          state_d      = RUN;
          mask_d       = mask_i;
          mode_d       = mode_i;
          tmo_en_d     = |timeout_i;
          cnt_d        = timeout_i;
          reported_d   = '0;
          fail_d       = '0;
          timeout_d    = 1'b0;
          exit_code_d  = '0;
          first_chan_d = '0;
        end
      end
      RUN: begin
        reported_d = rep_post;
        fail_d     = fail_post;
        // Only the earliest failure supplies the exit code.
        if (fail_q == '0 && new_fail != '0) begin
          exit_code_d  = fail_code;
          first_chan_d = fail_idx;
        end
        if (tmo_en_q) cnt_d = cnt_q - TimeoutWidth'(1);
        if (complete) begin
          state_d = DONE;
        end else if (expire) begin
          state_d      = DONE;
          timeout_d    = 1'b1;
          exit_code_d  = '1;
          first_chan_d = pend_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      tmo_en_q     <= 1'b0;
      cnt_q        <= '0;
      reported_q   <= '0;
      fail_q       <= '0;
      timeout_q    <= 1'b0;
      exit_code_q  <= '0;
      first_chan_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      tmo_en_q     <= tmo_en_d;
      cnt_q        <= cnt_d;
      reported_q   <= reported_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      exit_code_q  <= exit_code_d;
      first_chan_q <= first_chan_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign timeout_o    = timeout_q;
  assign exit_code_o  = exit_code_q;
  assign first_chan_o = first_chan_q;
  assign reported_o   = reported_q;
  assign fail_mask_o  = fail_q;

endmodule

// File: tb/tb_pb_eoc_aggregator.sv
// Bench for pb_eoc_aggregator: directed scenarios from the block's intended
// use plus randomized report streams, checked against an outcome model that
// works from each channel's first valid report time.
module tb_pb_eoc_aggregator;
  localparam int NC = 4, CW = 8, TW = 16, CIW = 2, MAXS = 24, NONE = 1000;

  logic              clk_i = 1'b0, rst_i = 1'b1, arm_i = 1'b0, mode_i = 1'b0;
  logic [NC-1:0]     mask_i = '0, eoc_valid_i = '0;
  logic [TW-1:0]     timeout_i = '0;
  logic [NC*CW-1:0]  eoc_code_i = '0;
  logic              busy_o, done_o, timeout_o;
  logic [CW-2:0]     exit_code_o;
  logic [CIW-1:0]    first_chan_o;
  logic [NC-1:0]     reported_o, fail_mask_o;

  pb_eoc_aggregator #(.NumChannels(NC), .CodeWidth(CW), .TimeoutWidth(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .mask_i(mask_i), .mode_i(mode_i),
    .timeout_i(timeout_i), .eoc_valid_i(eoc_valid_i), .eoc_code_i(eoc_code_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .exit_code_o(exit_code_o),
    .first_chan_o(first_chan_o), .reported_o(reported_o), .fail_mask_o(fail_mask_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0;

  // Stimulus tables: step k is sampled at the k-th edge after the arm edge.
  logic [NC-1:0] st_v   [MAXS+1];
  logic [CW-1:0] st_c   [MAXS+1][NC];
  bit            st_arm [MAXS+1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_scn();
    for (int k = 0; k <= MAXS; k++) begin
      st_v[k] = '0;
      st_arm[k] = 1'b0;
      for (int c = 0; c < NC; c++) st_c[k][c] = '0;
    end
  endtask

  task automatic put(input int k, input int c, input logic [CW-1:0] code);
    st_v[k][c] = 1'b1;
    st_c[k][c] = code;
  endtask

  // Reset for one cycle with reports present; everything must read zero.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; arm_i = 1'b0;
    eoc_valid_i = '1;
    for (int c = 0; c < NC; c++) eoc_code_i[c*CW +: CW] = 8'h03;
    @(posedge clk_i); #1;
    chk("rst_busy", busy_o, 0);      chk("rst_done", done_o, 0);
    chk("rst_tmo", timeout_o, 0);    chk("rst_exit", exit_code_o, 0);
    chk("rst_first", first_chan_o, 0);
    chk("rst_rep", reported_o, 0);   chk("rst_fail", fail_mask_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0; eoc_valid_i = '0;
  endtask

  // Arm, play the stimulus table and compare every step against the model.
  task automatic run_scn(input logic [NC-1:0] mask, input bit mode, input int tmo,
                         input int nsteps);
    int fs[NC];
    logic [CW-2:0] rv[NC];
    int comp, fin, lim, best, e_first;
    bit to;
    logic [NC-1:0] e_rep, e_fail;
    logic [CW-2:0] e_exit;
    // Model: each masked channel's first EOC-flagged report time decides all.
    for (int c = 0; c < NC; c++) begin
      fs[c] = NONE; rv[c] = '0;
      if (mask[c])
        for (int k = 1; k <= nsteps; k++)
          if (fs[c] == NONE && st_v[k][c] && st_c[k][c][0]) begin
            fs[c] = k; rv[c] = st_c[k][c][CW-1:1];
          end
    end
    comp = 1;
    for (int c = 0; c < NC; c++) if (mask[c] && fs[c] > comp) comp = fs[c];
    if (mode)
      for (int c = 0; c < NC; c++)
        if (mask[c] && fs[c] != NONE && rv[c] != 0 && fs[c] < comp) comp = fs[c];
    fin = comp; to = 1'b0;
    if (tmo > 0 && tmo < comp) begin fin = tmo; to = 1'b1; end
    e_exit = '0; e_first = 0; best = NONE;
    if (to) begin
      e_exit = '1;
      for (int c = NC - 1; c >= 0; c--) if (mask[c] && fs[c] > fin) e_first = c;
    end else begin
      for (int c = 0; c < NC; c++)
        if (fs[c] <= fin && rv[c] != 0 && fs[c] < best) begin
          best = fs[c]; e_exit = rv[c]; e_first = c;
        end
    end

    @(negedge clk_i);
    arm_i = 1'b1; mask_i = mask; mode_i = mode; timeout_i = TW'(tmo); eoc_valid_i = '0;
    @(posedge clk_i); #1;
    chk("arm_busy", busy_o, 1); chk("arm_done", done_o, 0); chk("arm_rep", reported_o, 0);
    for (int k = 1; k <= nsteps; k++) begin
      @(negedge clk_i);
      arm_i = st_arm[k] && (k <= fin);  // only ever lands while RUN
      mask_i = NC'($urandom); mode_i = 1'($urandom); timeout_i = TW'($urandom);
      eoc_valid_i = st_v[k];
      for (int c = 0; c < NC; c++) eoc_code_i[c*CW +: CW] = st_c[k][c];
      @(posedge clk_i); #1;
      lim = (k < fin) ? k : fin;
      e_rep = '0; e_fail = '0;
      for (int c = 0; c < NC; c++)
        if (fs[c] <= lim) begin e_rep[c] = 1'b1; e_fail[c] = (rv[c] != 0); end
      chk("busy", busy_o, k < fin);
      chk("done", done_o, k >= fin);
      chk("reported", reported_o, e_rep);
      chk("fail_mask", fail_mask_o, e_fail);
      if (k >= fin) begin
        chk("timeout", timeout_o, to);
        chk("exit_code", exit_code_o, e_exit);
        chk("first_chan", first_chan_o, e_first);
      end
    end
  endtask

  initial begin
    do_reset();

    // WAIT_ALL, all four report success at steps 3, 5, 5, 9.
    clr_scn();
    put(3, 0, 8'h01); put(5, 1, 8'h01); put(5, 2, 8'h01); put(9, 3, 8'h01);
    run_scn(4'b1111, 1'b0, 0, 11);
    chk("d1_exit", exit_code_o, 0); chk("d1_fail", fail_mask_o, 0); chk("d1_tmo", timeout_o, 0);

    // FIRST_FAIL: ch2 returns 3 and ends the run early.
    clr_scn();
    put(4, 2, 8'h07);
    run_scn(4'b0111, 1'b1, 0, 6);
    chk("d2_exit", exit_code_o, 3); chk("d2_first", first_chan_o, 2);
    chk("d2_rep", reported_o, 4'b0100);

    // Same-cycle failures: lowest index wins; repeat report has no effect.
    clr_scn();
    put(2, 1, 8'h0B); put(2, 3, 8'h05); put(3, 0, 8'h01); put(3, 2, 8'h01);
    put(4, 1, 8'h03);
    run_scn(4'b1111, 1'b0, 0, 6);
    chk("d3_exit", exit_code_o, 5); chk("d3_first", first_chan_o, 1);
    chk("d3_fail", fail_mask_o, 4'b1010);

    // Timeout with ch1 never reporting.
    clr_scn();
    put(2, 0, 8'h01);
    run_scn(4'b0011, 1'b0, 10, 12);
    chk("d4_tmo", timeout_o, 1); chk("d4_exit", exit_code_o, 7'h7F);
    chk("d4_first", first_chan_o, 1);

    // Completion coincides with expiry; bit0=0 word and unmasked report ignored.
    clr_scn();
    put(2, 0, 8'h06); put(2, 2, 8'h01); put(5, 0, 8'h01);
    run_scn(4'b0001, 1'b0, 5, 7);
    chk("d5_tmo", timeout_o, 0); chk("d5_rep", reported_o, 4'b0001);

    // Empty mask: one RUN cycle then DONE.
    clr_scn();
    run_scn(4'b0000, 1'b0, 0, 3);
    chk("d6_exit", exit_code_o, 0);

    // Reset three cycles after arm while reports arrive, then re-arm cleanly.
    clr_scn();
    put(1, 0, 8'h05); put(2, 1, 8'h01);
    run_scn(4'b1111, 1'b0, 0, 2);
    do_reset();
    clr_scn();
    put(1, 0, 8'h01); put(1, 1, 8'h01); put(2, 2, 8'h09); put(3, 3, 8'h01);
    run_scn(4'b1111, 1'b0, 0, 5);
    chk("d7_exit", exit_code_o, 4); chk("d7_first", first_chan_o, 2);
    do_reset();

    // Randomized scenarios.
    for (int s = 0; s < 40; s++) begin
      logic [NC-1:0] msk;
      bit md;
      int tmo;
      clr_scn();
      msk = NC'($urandom_range(0, 15));
      md  = 1'($urandom_range(0, 1));
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      for (int k = 1; k <= MAXS; k++) begin
        st_arm[k] = ($urandom_range(0, 7) == 0);
        for (int c = 0; c < NC; c++)
          if ($urandom_range(0, 5) == 0) begin
            logic [CW-2:0] ret;
            ret = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            put(k, c, {ret, 1'($urandom_range(0, 3) != 0)});
          end
      end
      run_scn(msk, md, tmo, MAXS);
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
endmodule
